wb_reg_bank: RTL and testbench
==============================

WB_REG_BANK -- requirements
Module: wb_reg_bank

Interface
REQ-001 SHALL have parameter REG_COUNT, default 1, meaning number of registers, 1..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning register width.
REQ-003 SHALL have parameter ADDR_WIDTH, default bit_width(REG_COUNT), meaning register index width.
REQ-004 SHALL have parameter RESET_VALUE, default 0, meaning packed REG_COUNT*DATA_WIDTH reset image.
REQ-005 SHALL have parameter W1C_MASK, default 0, meaning packed per-bit sticky-event bits (write-1-to-clear).
REQ-006 SHALL have parameter PULSE_MASK, default 0, meaning packed per-bit self-clearing bits.
REQ-007 SHALL have parameter PULSE_CYCLES, default 64, meaning self-clear hold time in cycles, >=1.
REQ-008 SHALL have port wb_clock_i, input, 1, meaning the single clock.
REQ-009 SHALL have port wb_reset_i, input, 1, meaning asynchronous active-high reset.
REQ-010 SHALL have port wb_addr_i, input, ADDR_WIDTH, meaning register index.
REQ-011 SHALL have port wb_data_i, input, DATA_WIDTH, meaning write data.
REQ-012 SHALL have port wb_data_o, output, DATA_WIDTH, meaning read data.
REQ-013 SHALL have port wb_we_i, input, 1, meaning write enable.
REQ-014 SHALL have port wb_cycle_i, input, 1, meaning bus cycle.
REQ-015 SHALL have port wb_strobe_i, input, 1, meaning request strobe.
REQ-016 SHALL have port wb_stall_o, output, 1, meaning stall (tied 0).
REQ-017 SHALL have port wb_ack_o, output, 1, meaning acknowledge.
REQ-018 SHALL have port event_i, input, REG_COUNT*DATA_WIDTH, meaning hardware set pulses for W1C bits.
REQ-019 SHALL have port regs_o, output, REG_COUNT*DATA_WIDTH, meaning live register image.

Function
REQ-020 SHALL accept a request every cycle cycle_i&strobe_i is high (pipelined Wishbone, no stall).
REQ-021 SHALL assert wb_ack_o exactly one cycle after each accepted request; back-to-back requests give back-to-back acks.
REQ-022 SHALL register wb_data_o with the addressed register value sampled at acceptance; wb_data_o is 0 when no ack.
REQ-023 SHALL update plain bits on write with wb_data_i, visible on regs_o the cycle after acceptance.
REQ-024 SHALL set W1C bits when the matching event_i bit is 1; a written 1 clears, a written 0 holds.
REQ-025 SHALL give event_i set priority over a same-cycle W1C clear.
REQ-026 SHALL, on write 1 to a PULSE bit, hold it 1 for exactly PULSE_CYCLES cycles, then clear it to 0.
REQ-027 SHALL keep one counter per register containing PULSE bits; rewriting 1 mid-count restarts the count; writing 0 clears immediately and idles the counter.
REQ-028 SHALL treat an address >= REG_COUNT as unmapped: ack normally, read 0, ignore writes.
REQ-029 SHALL ignore strobe_i when cycle_i is low; dropping cycle_i does not cancel a pending ack.

Reset
REQ-030 SHALL, while wb_reset_i is high, drive wb_ack_o=0, wb_data_o=0, registers=RESET_VALUE, pulse counters idle.
REQ-031 SHALL restart RESET_VALUE pulse bits with a full PULSE_CYCLES count on the first edge after reset release (CPU reset held after power-up).
REQ-032 SHALL discard any request or pulse in flight when reset asserts mid-operation.

Structure
REQ-033 SHALL place register indices, bit positions and per-register mask/reset constants (CPU ready, CPU reset-pulse) in common_pkg.
REQ-034 SHALL implement the self-clear timer as one sub-module, pulse_timer, instantiated per register holding PULSE bits.
REQ-035 SHALL use common_pkg bit_width for counter and address widths.

Verification
REQ-036 Reset, REG_COUNT=2, RESET_VALUE=16'h0001 -> regs_o=16'h0001, ack=0, data_o=0.
REQ-037 Write 8'hA5 to reg 0, then read reg 0 back-to-back -> acks on consecutive cycles, read returns 8'hA5.
REQ-038 W1C bit 0 of reg 1: event pulse -> reads 1; write 8'h01 -> reads 0; event and write same cycle -> stays 1.
REQ-039 PULSE bit 1, PULSE_CYCLES=4: write 8'h02 -> bit high exactly 4 cycles; rewrite at cycle 2 -> high 6 cycles total.
REQ-040 Read address 3 with REG_COUNT=2 -> ack in 1 cycle, data 8'h00; write there leaves regs_o unchanged.
REQ-041 Reset asserted mid-pulse -> bit returns to reset value immediately; after release pulse restarts at full count.

Source files
------------

// File: rtl/common_pkg.sv
// Shared constants for the register bank: register map, bit positions,
// per-register mask/reset images and the width helper used for sizing.
package common_pkg;

    // Bits needed to hold the value itself (not value-1), so an index one
    // past the last register is still representable.
    function automatic int bit_width(input int value);
        int w;
        w = 1;
        while ((1 << w) <= value) w++;
        return w;
    endfunction

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;

    localparam int CTRL_CPU_RESET_BIT   = 0;
    localparam int CTRL_CPU_KICK_BIT    = 1;
    localparam int STATUS_CPU_READY_BIT = 0;

    localparam logic [7:0] CTRL_RESET_VALUE   = 8'h01;
    localparam logic [7:0] CTRL_PULSE_MASK    = 8'h03;
    localparam logic [7:0] STATUS_RESET_VALUE = 8'h00;
    localparam logic [7:0] STATUS_W1C_MASK    = 8'h01;

endpackage

// File: rtl/pulse_timer.sv
// Self-clear timer for one register's PULSE bits: flags expiry after
// PULSE_CYCLES cycles, optionally starting right after reset release.
module pulse_timer
    import common_pkg::*;
#(
    parameter int PULSE_CYCLES     = 64,
    parameter bit START_AT_RELEASE = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_clear,
    output logic o_expire
);

    localparam int CNT_W = bit_width(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(PULSE_CYCLES);

    logic [CNT_W-1:0] r_count;
    logic             r_first;
    logic             w_start;

    // A bit that comes out of reset already set gets a fresh full count,
    // unless the very first bus write overrides it.
    assign w_start = i_load || (r_first && START_AT_RELEASE && !i_clear);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (w_start)
                r_count <= LOAD_VALUE;
            else if (i_clear)
                r_count <= '0;
            else if (r_count != '0)
                r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expire = (r_count == CNT_W'(1)) && !w_start && !i_clear;

endmodule

// File: rtl/wb_reg_bank.sv
// Pipelined Wishbone register bank with plain, write-1-to-clear sticky and
// self-clearing pulse bits; one-cycle ack, never stalls.
module wb_reg_bank
    import common_pkg::*;
#(
    parameter int                              REG_COUNT    = 1,
    parameter int                              DATA_WIDTH   = 8,
    parameter int                              ADDR_WIDTH   = bit_width(REG_COUNT),
    parameter logic [REG_COUNT*DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter logic [REG_COUNT*DATA_WIDTH-1:0] W1C_MASK     = '0,
    parameter logic [REG_COUNT*DATA_WIDTH-1:0] PULSE_MASK   = '0,
    parameter int                              PULSE_CYCLES = 64
) (
    input  logic                            wb_clock_i,
    input  logic                            wb_reset_i,
    input  logic [ADDR_WIDTH-1:0]           wb_addr_i,
    input  logic [DATA_WIDTH-1:0]           wb_data_i,
    output logic [DATA_WIDTH-1:0]           wb_data_o,
    input  logic                            wb_we_i,
    input  logic                            wb_cycle_i,
    input  logic                            wb_strobe_i,
    output logic                            wb_stall_o,
    output logic                            wb_ack_o,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] event_i,
    output logic [REG_COUNT*DATA_WIDTH-1:0] regs_o
);

    logic                                w_accept;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] w_regs;
    logic [DATA_WIDTH-1:0]               w_rdata;
    logic                                r_ack;
    logic [DATA_WIDTH-1:0]               r_data;

    assign w_accept = wb_cycle_i & wb_strobe_i;

    // Unmapped indices match no register and therefore read as zero.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < REG_COUNT; i++)
            if (wb_addr_i == ADDR_WIDTH'(i))
                w_rdata = w_regs[i];
    end

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_ack  <= 1'b0;
            r_data <= '0;
        end else begin
            r_ack  <= w_accept;
            r_data <= w_accept ? w_rdata : '0;
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg
        localparam logic [DATA_WIDTH-1:0] RST_V   = RESET_VALUE[g*DATA_WIDTH +: DATA_WIDTH];
        localparam logic [DATA_WIDTH-1:0] W1C_M   = W1C_MASK[g*DATA_WIDTH +: DATA_WIDTH];
        localparam logic [DATA_WIDTH-1:0] PULSE_M = PULSE_MASK[g*DATA_WIDTH +: DATA_WIDTH];

        logic                  w_write;
        logic                  w_expire;
        logic [DATA_WIDTH-1:0] w_wmask;
        logic [DATA_WIDTH-1:0] w_next;
        logic [DATA_WIDTH-1:0] r_value;

        assign w_write = w_accept & wb_we_i & (wb_addr_i == ADDR_WIDTH'(g));
        assign w_wmask = w_write ? wb_data_i : '0;

        // Sticky bits OR in the event after the clear so a same-cycle event wins.
        always_comb begin
            w_next = (w_write ? wb_data_i : r_value) & ~W1C_M;
            if (w_expire)
                w_next = w_next & ~PULSE_M;
            w_next = w_next | (((r_value & ~w_wmask) | event_i[g*DATA_WIDTH +: DATA_WIDTH]) & W1C_M);
        end

        always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
            if (wb_reset_i)
                r_value <= RST_V;
            else
                r_value <= w_next;
        end

        if (PULSE_M != '0) begin : g_timer
            logic w_load;
            logic w_clear;

            assign w_load  = w_write && (|(wb_data_i & PULSE_M));
            assign w_clear = w_write && !(|(wb_data_i & PULSE_M));

            pulse_timer #(
                .PULSE_CYCLES    (PULSE_CYCLES),
                .START_AT_RELEASE((RST_V & PULSE_M) != '0)
            ) u_timer (
                .i_clock (wb_clock_i),
                .i_reset (wb_reset_i),
                .i_load  (w_load),
                .i_clear (w_clear),
                .o_expire(w_expire)
            );
        end else begin : g_no_timer
            assign w_expire = 1'b0;
        end

        assign w_regs[g] = r_value;
    end

    assign regs_o     = w_regs;
    assign wb_data_o  = r_data;
    assign wb_ack_o   = r_ack;
    assign wb_stall_o = 1'b0;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Scoreboard bench for wb_reg_bank: directed scenarios then random traffic,
// compared against a cycle-deadline reference model of the register bank.
module tb_wb_reg_bank;
    import common_pkg::*;

    localparam int REG_COUNT    = 2;
    localparam int DATA_WIDTH   = 8;
    localparam int ADDR_WIDTH   = 2;
    localparam int PULSE_CYCLES = 4;
    localparam logic [15:0] RESET_VALUE = {STATUS_RESET_VALUE, CTRL_RESET_VALUE};
    localparam logic [15:0] W1C_MASK    = {STATUS_W1C_MASK, 8'h00};
    localparam logic [15:0] PULSE_MASK  = {8'h00, CTRL_PULSE_MASK};

    logic        wbClock  = 1'b0;
    logic        wbReset  = 1'b1;
    logic [1:0]  addrIn   = '0;
    logic [7:0]  dataIn   = '0;
    logic        weIn     = 1'b0;
    logic        cycleIn  = 1'b0;
    logic        strobeIn = 1'b0;
    logic [15:0] evIn     = '0;
    logic [7:0]  dataOut;
    logic        stallOut;
    logic        ackOut;
    logic [15:0] regsOut;

    int  checkCount = 0;
    int  passCount  = 0;
    bit  monitorOn  = 1'b0;

    int  mReg[REG_COUNT];
    int  deadline[REG_COUNT];
    int  cycleNo;
    bit  mFirst;
    bit  mAck;
    int  expQ[$];

    wb_reg_bank #(
        .REG_COUNT   (REG_COUNT),
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .W1C_MASK    (W1C_MASK),
        .PULSE_MASK  (PULSE_MASK),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) dut (
        .wb_clock_i (wbClock),
        .wb_reset_i (wbReset),
        .wb_addr_i  (addrIn),
        .wb_data_i  (dataIn),
        .wb_data_o  (dataOut),
        .wb_we_i    (weIn),
        .wb_cycle_i (cycleIn),
        .wb_strobe_i(strobeIn),
        .wb_stall_o (stallOut),
        .wb_ack_o   (ackOut),
        .event_i    (evIn),
        .regs_o     (regsOut)
    );

    initial forever #5 wbClock = ~wbClock;

    function automatic int slice(input logic [15:0] img, input int r);
        return (int'(img) >> (8 * r)) & 'hFF;
    endfunction

    function automatic void resetModel();
        for (int r = 0; r < REG_COUNT; r++) begin
            mReg[r]     = slice(RESET_VALUE, r);
            deadline[r] = -1;
        end
        cycleNo = 0;
        mFirst  = 1'b1;
        mAck    = 1'b0;
        expQ.delete();
    endfunction

    // Pulse bits are tracked as an absolute clear deadline rather than a counter.
    function automatic void modelStep();
        bit accept;
        bit written;
        int wd, pm, wm, ev, oldV, plainV, pulseV, stickyV;
        accept = cycleIn && strobeIn;
        wd     = int'(dataIn);
        cycleNo++;
        if (accept) begin
            if (int'(addrIn) < REG_COUNT) expQ.push_back(mReg[int'(addrIn)]);
            else                          expQ.push_back(0);
        end
        for (int r = 0; r < REG_COUNT; r++) begin
            oldV    = mReg[r];
            written = accept && weIn && (int'(addrIn) == r);
            pm      = slice(PULSE_MASK, r);
            wm      = slice(W1C_MASK, r);
            ev      = slice(evIn, r);
            plainV  = (written ? wd : oldV) & ~pm & ~wm;
            pulseV  = oldV & pm;
            if (written) begin
                pulseV      = wd & pm;
                deadline[r] = (pulseV != 0) ? cycleNo + PULSE_CYCLES : -1;
            end else if (mFirst && (slice(RESET_VALUE, r) & pm) != 0) begin
                deadline[r] = cycleNo + PULSE_CYCLES;
            end else if (deadline[r] == cycleNo) begin
                pulseV      = 0;
                deadline[r] = -1;
            end
            stickyV = ((oldV & ~(written ? wd : 0)) | ev) & wm;
            mReg[r] = plainV | pulseV | stickyV;
        end
        mFirst = 1'b0;
        mAck   = accept;
    endfunction

    always @(posedge wbClock) begin
        if (!wbReset) modelStep();
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    always @(negedge wbClock) begin
        int expData;
        if (monitorOn) begin
            checkOutput("stall", int'(stallOut), 0);
            checkOutput("ack", int'(ackOut), int'(mAck));
            if (ackOut === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL rdata_unexpected: got ack with data %h, expected no ack", dataOut);
                end else begin
                    expData = expQ.pop_front();
                    checkOutput("rdata", int'(dataOut), expData);
                end
            end else begin
                checkOutput("idle_data", int'(dataOut), 0);
            end
            checkOutput("regs", int'(regsOut), (mReg[1] << 8) | mReg[0]);
        end
    end

    task automatic applyStimulus(input bit cyc, input bit stb, input bit we,
                                 input logic [1:0] addr, input logic [7:0] data,
                                 input logic [15:0] ev);
        cycleIn  = cyc;
        strobeIn = stb;
        weIn     = we;
        addrIn   = addr;
        dataIn   = data;
        evIn     = ev;
        @(posedge wbClock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 16'h0000);
    endtask

    task automatic applyReset(input int cycles);
        wbReset  = 1'b1;
        cycleIn  = 1'b0;
        strobeIn = 1'b0;
        weIn     = 1'b0;
        evIn     = '0;
        resetModel();
        repeat (cycles) @(posedge wbClock);
        #1;
        wbReset = 1'b0;
    endtask

    initial begin
        logic [1:0] ctrlIdx;
        logic [1:0] statusIdx;
        logic [7:0] kick;
        logic [15:0] readyEvent;
        ctrlIdx    = 2'(REG_CTRL);
        statusIdx  = 2'(REG_STATUS);
        kick       = 8'(1 << CTRL_CPU_KICK_BIT);
        readyEvent = 16'(1 << (8 * REG_STATUS + STATUS_CPU_READY_BIT));

        resetModel();
        monitorOn = 1'b1;
        applyReset(3);
        idle(6);

        applyStimulus(1'b1, 1'b1, 1'b1, ctrlIdx, 8'hA5, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, ctrlIdx, 8'h00, 16'h0000);
        idle(6);

        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, readyEvent);
        applyStimulus(1'b1, 1'b1, 1'b0, statusIdx, 8'h00, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, statusIdx, 8'h01, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, statusIdx, 8'h00, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, statusIdx, 8'h01, readyEvent);
        applyStimulus(1'b1, 1'b1, 1'b0, statusIdx, 8'h00, 16'h0000);

        applyStimulus(1'b1, 1'b1, 1'b1, ctrlIdx, kick, 16'h0000);
        idle(6);
        applyStimulus(1'b1, 1'b1, 1'b1, ctrlIdx, kick, 16'h0000);
        idle(1);
        applyStimulus(1'b1, 1'b1, 1'b1, ctrlIdx, kick, 16'h0000);
        idle(8);

        applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 8'h00, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 8'hFF, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, ctrlIdx, 8'h3C, 16'h0000);
        idle(2);

        applyStimulus(1'b1, 1'b1, 1'b1, ctrlIdx, kick, 16'h0000);
        idle(1);
        applyReset(2);
        idle(8);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                applyReset(2);
            end else begin
                applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                              1'($urandom), 2'($urandom), 8'($urandom),
                              16'($urandom & $urandom & $urandom));
            end
        end
        idle(3);
        monitorOn = 1'b0;
        checkOutput("drain", expQ.size(), 0);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
